// File: rtl/scale_pixel_gen_mc.sv
// Bilinear 2x2 pixel generator: four image-cache reads per pixel, 4-stage interpolation pipeline.
// Optional round-half-up of the final shift when SCALE_PIX_ROUND_EN is defined (truncates otherwise).
module scale_pixel_gen_mc #(
  parameter int PIX_W  = 8,
  parameter int CH     = 1,
  parameter int FRAC_W = 12,
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  ready,
  input  logic [ADDR_W-1:0]     sx,
  input  logic [ADDR_W-1:0]     sy,
  input  logic [FRAC_W-1:0]     fx,
  input  logic [FRAC_W-1:0]     fy,
  input  logic [ADDR_W-1:0]     dx,
  input  logic [ADDR_W-1:0]     dy,
  input  logic [ADDR_W-1:0]     max_x,
  input  logic [ADDR_W-1:0]     max_y,
  output logic [ADDR_W-1:0]     raddr_x,
  output logic [ADDR_W-1:0]     raddr_y,
  input  logic [CH*PIX_W-1:0]   rdata,
  output logic [ADDR_W-1:0]     waddr_x,
  output logic [ADDR_W-1:0]     waddr_y,
  output logic [CH*PIX_W-1:0]   wdata,
  output logic                  we
);

  localparam int DATA_W = CH * PIX_W;
  localparam int PROD_W = PIX_W + 2 * FRAC_W + 1;
  localparam logic [FRAC_W:0] ONE = {1'b1, {FRAC_W{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_RA, S_RB, S_RC, S_RD} state_t;

  state_t              state;
  logic                accept;

  logic [ADDR_W-1:0]   sx_r, sy_r, dx_r, dy_r;
  logic [FRAC_W-1:0]   fx_r, fy_r;
  logic [ADDR_W-1:0]   x1, y1;

  logic [FRAC_W:0]     wx0, wx1, wy0, wy1;
  logic [FRAC_W-1:0]   p1_fy, p2_fy;
  logic [ADDR_W-1:0]   p1_dx, p1_dy, p2_dx, p2_dy, p3_dx, p3_dy;
  logic                v1, v2, v3;
  logic [DATA_W-1:0]   pix_next;

  assign accept = start && ready;

  // Edge clamp keeps every read inside the source image.
  assign x1 = (sx_r >= max_x) ? sx_r : sx_r + ADDR_W'(1);
  assign y1 = (sy_r >= max_y) ? sy_r : sy_r + ADDR_W'(1);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    raddr_x = '0;
    raddr_y = '0;
    case (state)
      S_IDLE, S_RD: begin
        if (start) begin
          raddr_x = sx;
          raddr_y = sy;
        end
      end
      S_RA: begin
        raddr_x = x1;
        raddr_y = sy_r;
      end
      S_RB: begin
        raddr_x = sx_r;
        raddr_y = y1;
      end
      S_RC: begin
        raddr_x = x1;
        raddr_y = y1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ready <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RA;
            ready <= 1'b0;
          end
        end
        S_RA: state <= S_RB;
        S_RB: state <= S_RC;
        S_RC: begin
          state <= S_RD;
          ready <= 1'b1;
        end
        S_RD: begin
          state <= start ? S_RA : S_IDLE;
          ready <= !start;
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  // Valid chain and write port; reset drops every in-flight pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      we      <= 1'b0;
      wdata   <= '0;
      waddr_x <= '0;
      waddr_y <= '0;
    end else begin
      v1 <= (state == S_RD);
      v2 <= v1;
      v3 <= v2;
      we <= v3;
      if (v3) begin
        wdata   <= pix_next;
        waddr_x <= p3_dx;
        waddr_y <= p3_dy;
      end
    end
  end

  // NOTE: request and pipeline data registers carry no reset; the valid chain alone qualifies them.
  always_ff @(posedge clk) begin
    if (accept) begin
      sx_r <= sx;
      sy_r <= sy;
      fx_r <= fx;
      fy_r <= fy;
      dx_r <= dx;
      dy_r <= dy;
    end
    // Request regs still hold the in-flight pixel during RD, even if a new one is accepted.
    if (state == S_RD) begin
      p1_fy <= fy_r;
      p1_dx <= dx_r;
      p1_dy <= dy_r;
    end
    p2_fy <= p1_fy;
    p2_dx <= p1_dx;
    p2_dy <= p1_dy;
    p3_dx <= p2_dx;
    p3_dy <= p2_dy;
  end

  assign wx1 = {1'b0, fx_r};
  assign wx0 = ONE - wx1;
  assign wy1 = {1'b0, p2_fy};
  assign wy0 = ONE - wy1;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [PIX_W-1:0]  a_q, b_q, c_q, d_in;
    logic [PROD_W-1:0] h_a, h_b, h_c, h_d;
    logic [PROD_W-1:0] top, bot, v_t, v_b, sum;

    assign d_in = rdata[g*PIX_W +: PIX_W];

    always_ff @(posedge clk) begin
      case (state)
        S_RA:    a_q <= d_in;
        S_RB:    b_q <= d_in;
        S_RC:    c_q <= d_in;
        default: ;
      endcase
      // D is consumed straight from the cache bus in RD, folding its capture into P1.
      if (state == S_RD) begin
        h_a <= PROD_W'(a_q)  * PROD_W'(wx0);
        h_b <= PROD_W'(b_q)  * PROD_W'(wx1);
        h_c <= PROD_W'(c_q)  * PROD_W'(wx0);
        h_d <= PROD_W'(d_in) * PROD_W'(wx1);
      end
      top <= h_a + h_b;
      bot <= h_c + h_d;
      v_t <= top * PROD_W'(wy0);
      v_b <= bot * PROD_W'(wy1);
    end

`ifdef SCALE_PIX_ROUND_EN
    localparam logic [PROD_W-1:0] RND = PROD_W'(1) << (2 * FRAC_W - 1);
    assign sum = v_t + v_b + RND;
`else
    assign sum = v_t + v_b;
`endif

    assign pix_next[g*PIX_W +: PIX_W] = PIX_W'(sum >> (2 * FRAC_W));
  end

endmodule

// File: tb/tb_scale_pixel_gen_mc.sv
// Self-checking bench for scale_pixel_gen_mc (3 channels): directed cases plus random requests
// checked against a bilinear reference model over a bench-side image cache.
module tb_scale_pixel_gen_mc;

  localparam int PW  = 8;
  localparam int CH  = 3;
  localparam int FW  = 12;
  localparam int AW  = 16;
  localparam int DW  = CH * PW;
  localparam longint ONE_L = 64'(1) << FW;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] sx, sy, dx, dy, max_x, max_y;
  logic [FW-1:0] fx, fy;
  logic          ready, we;
  logic [AW-1:0] raddr_x, raddr_y, waddr_x, waddr_y;
  logic [DW-1:0] rdata, wdata;

  scale_pixel_gen_mc #(.PIX_W(PW), .CH(CH), .FRAC_W(FW), .ADDR_W(AW)) u_dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready),
    .sx(sx), .sy(sy), .fx(fx), .fy(fy), .dx(dx), .dy(dy),
    .max_x(max_x), .max_y(max_y),
    .raddr_x(raddr_x), .raddr_y(raddr_y), .rdata(rdata),
    .waddr_x(waddr_x), .waddr_y(waddr_y), .wdata(wdata), .we(we)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [AW-1:0] dx;
    logic [AW-1:0] dy;
    logic [DW-1:0] pix;
  } exp_t;

  logic [DW-1:0] img [64][64];
  exp_t          exp_q[$];
  exp_t          mon_e;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_pass = 0;
  int            oob = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Image cache: one-cycle read latency.
  always @(posedge clk)
    rdata <= (raddr_x < 64 && raddr_y < 64) ? img[raddr_y[5:0]][raddr_x[5:0]] : '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] model(input int sxi, input int syi, input int fxi, input int fyi);
    logic [DW-1:0] r;
    int            x1, y1;
    longint        a, b, c, d, s;
    x1 = (sxi >= int'(max_x)) ? sxi : sxi + 1;
    y1 = (syi >= int'(max_y)) ? syi : syi + 1;
    r  = '0;
    for (int ch = 0; ch < CH; ch++) begin
      a = longint'(img[syi][sxi][ch*PW +: PW]);
      b = longint'(img[syi][x1][ch*PW +: PW]);
      c = longint'(img[y1][sxi][ch*PW +: PW]);
      d = longint'(img[y1][x1][ch*PW +: PW]);
      s = (a * (ONE_L - fxi) + b * fxi) * (ONE_L - fyi) + (c * (ONE_L - fxi) + d * fxi) * fyi;
`ifdef SCALE_PIX_ROUND_EN
      s = s + (64'(1) << (2 * FW - 1));
`endif
      r[ch*PW +: PW] = PW'(s >> (2 * FW));
    end
    return r;
  endfunction

  // Write-port monitor: every expected pulse must land on its cycle with its own address/data.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        mon_e = exp_q.pop_front();
        check("we_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("we", we, 1);
        check("waddr_x", waddr_x, mon_e.dx);
        check("waddr_y", waddr_y, mon_e.dy);
        check("wdata", wdata, mon_e.pix);
      end else if (we !== 1'b0) begin
        check("unexpected_we", we, 0);
      end
      if (raddr_x > max_x || raddr_y > max_y) oob++;
    end
  end

  task automatic send(input int sxi, input int syi, input int fxi, input int fyi,
                      input int dxi, input int dyi, input bit keep, output int t);
    int   guard;
    exp_t e;
    guard = 0;
    t = -1;
    while (ready !== 1'b1) begin
      // Garbage on the request bus while busy must not be latched.
      if (start) begin
        sx = AW'($urandom); sy = AW'($urandom); fx = FW'($urandom);
        fy = FW'($urandom); dx = AW'($urandom); dy = AW'($urandom);
      end
      @(negedge clk);
      guard++;
      if (guard > 20) begin
        check("ready_timeout", ready, 1);
        start = 1'b0;
        return;
      end
    end
    sx = AW'(sxi); sy = AW'(syi); fx = FW'(fxi); fy = FW'(fyi);
    dx = AW'(dxi); dy = AW'(dyi);
    start = 1'b1;
    t     = cyc;
    e.cyc = cyc + 8;
    e.dx  = AW'(dxi);
    e.dy  = AW'(dyi);
    e.pix = model(sxi, syi, fxi, fyi);
    exp_q.push_back(e);
    @(negedge clk);
    if (!keep) start = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", 64'(exp_q.size()), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic set_quad(input int x, input int y, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] c, input logic [DW-1:0] d);
    img[y][x]     = a;
    img[y][x+1]   = b;
    img[y+1][x]   = c;
    img[y+1][x+1] = d;
  endtask

  task automatic reset_during(input int offset);
    int t, wecnt;
    send(12, 14, $urandom_range(4095, 0), $urandom_range(4095, 0), 55, 66, 1'b0, t);
    repeat (offset - 1) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", ready, 1);
    check("reset_wdata", wdata, 0);
    wecnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (we === 1'b1) wecnt++;
    end
    check("no_we_after_reset", 64'(wecnt), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int t, t1, t2, n, rx, ry, rfx, rfy;
    logic [7:0] exp2;

    reset = 1'b1; start = 1'b0;
    sx = '0; sy = '0; fx = '0; fy = '0; dx = '0; dy = '0;
    max_x = AW'(63); max_y = AW'(63);
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 64; x++)
        img[y][x] = DW'($urandom);

    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_we", we, 0);
    check("rst_wdata", wdata, 0);
    check("rst_waddr_x", waddr_x, 0);
    check("rst_waddr_y", waddr_y, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1) zero weights select A
    set_quad(5, 7, 24'h01020A, 24'h030414, 24'h05061E, 24'h070828);
    send(5, 7, 0, 0, 100, 200, 1'b0, t);
    wait_drain();
    check("t1_wdata", wdata, 24'h01020A);
    check("t1_waddr_x", waddr_x, 100);
    check("t1_waddr_y", waddr_y, 200);

    // 2) half weights, truncation vs rounding
    set_quad(10, 12, {3{8'd10}}, {3{8'd20}}, {3{8'd30}}, {3{8'd42}});
    send(10, 12, 2048, 2048, 7, 9, 1'b0, t);
    wait_drain();
`ifdef SCALE_PIX_ROUND_EN
    exp2 = 8'd26;
`else
    exp2 = 8'd25;
`endif
    check("t2_wdata", wdata, {3{exp2}});

    // 3) back-to-back with start held
    send(3, 4, 1000, 3000, 11, 22, 1'b1, t1);
    send(30, 40, 4095, 17, 33, 44, 1'b0, t2);
    check("b2b_gap", 64'(t2 - t1), 4);
    wait_drain();

    // 4) right-edge clamp
    img[5][63] = {3{8'd100}};
    send(63, 5, 2048, 0, 1, 2, 1'b0, t);
    check("t4_raddr_x", raddr_x, 63);
    check("t4_raddr_y", raddr_y, 5);
    wait_drain();
    check("t4_wdata", wdata, {3{8'd100}});

    // bottom-edge clamp
    send(20, 63, 1234, 4000, 3, 3, 1'b0, t);
    wait_drain();

    // 6) independent channels
    img[20][20] = {8'd7, 8'd200, 8'd33};
    send(20, 20, 0, 0, 5, 6, 1'b0, t);
    wait_drain();
    check("t6_wdata", wdata, 24'h07C821);

    // 5) reset mid-request and with a loaded pipeline
    reset_during(3);
    reset_during(6);

    // random batches
    for (int b = 0; b < 10; b++) begin
      wait_drain();
      max_x = AW'($urandom_range(63, 1));
      max_y = AW'($urandom_range(63, 1));
      n = $urandom_range(5, 1);
      for (int i = 0; i < n; i++) begin
        rx  = ($urandom_range(3, 0) == 0) ? int'(max_x) : int'($urandom_range(int'(max_x), 0));
        ry  = ($urandom_range(3, 0) == 0) ? int'(max_y) : int'($urandom_range(int'(max_y), 0));
        rfx = ($urandom_range(4, 0) == 0) ? 4095 : int'($urandom_range(4095, 0));
        rfy = ($urandom_range(4, 0) == 0) ? 0 : int'($urandom_range(4095, 0));
        send(rx, ry, rfx, rfy, int'($urandom_range(65535, 0)), int'($urandom_range(65535, 0)),
             i != n - 1, t);
      end
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    wait_drain();
    check("no_out_of_range_read", 64'(oob), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
